serial_add_ctrl: RTL and testbench

//   Bit-serial multi-bit adder built around one one_bit_add instance.
//   - Latches two WIDTH-bit operands and a carry-in on a start request.
//   - Feeds one bit pair per clock, LSB first, into the full-adder cell.
//   - Stores the carry between cycles and collects the sum bits in a shift register.
//   - Delivers Sum/CO with a one-cycle done pulse; sits directly upstream of, and drives, one_bit_add.
//

---
 rtl/serial_add_ctrl_if.sv | 31 +++
 rtl/serial_add_ctrl.sv | 113 +++++++++++
 tb/tb_serial_add_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// Bus between a requester and the bit-serial adder: request side
// (start, operands, carry-in) and result side (busy, done, Sum, CO),
// plus the controller state for observation.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   // Handshake: start is a request and busy is the inverse of ready.
   // A request is accepted on a rising edge where start = 1 and busy = 0,
   // and A, B and CI are captured on that same edge. They may change
   // freely afterwards. Requests made while busy = 1 are dropped, not queued.
   // done pulses for one cycle when Sum and CO carry the new result.
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CI;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Sum;
   logic             CO;
   logic [1:0]       state_dbg;

   modport master (
      output start, A, B, CI,
      input  busy, done, Sum, CO, state_dbg
   );

   modport slave (
      input  start, A, B, CI,
      output busy, done, Sum, CO, state_dbg
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell is reused for WIDTH clocks.
// The operands are shifted LSB first, and the carry is held in a register
// between bits.

// Single-bit full adder cell driven by the controller below.
module one_bit_add (
   input  logic A,
   input  logic B,
   input  logic CI,
   output logic Sum,
   output logic CO
);
   assign Sum = A ^ B ^ CI;
   assign CO  = (A & B) | (A & CI) | (B & CI);
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_add_ctrl_if.slave    bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] op_a, op_b;
   // Holds the WIDTH-1 sum bits already produced. The newest bit is
   // concatenated on top, so the full word exists on the last edge.
   logic [WIDTH-2:0] sum_sh;
   logic             carry;
   logic [5:0]       cnt;
   logic [WIDTH-1:0] sum_q;
   logic             co_q;
   logic             cell_s, cell_co;
   logic [WIDTH-1:0] sum_next;
   logic             last_bit;

   one_bit_add u_cell (
      .A   (op_a[0]),
      .B   (op_b[0]),
      .CI  (carry),
      .Sum (cell_s),
      .CO  (cell_co)
   );

   assign sum_next = {cell_s, sum_sh};
   assign last_bit = (cnt == 6'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state decode: IDLE waits for start, ADD runs WIDTH bits, DONE lasts one cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = ADD;
         ADD:     if (last_bit)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture operands on acceptance and shift one bit per ADD
   // cycle. The result registers are loaded only on the final bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_a   <= '0;
         op_b   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         co_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_a  <= bus.A;
                  op_b  <= bus.B;
                  carry <= bus.CI;
                  cnt   <= '0;
               end
            end
            ADD: begin
               op_a   <= op_a >> 1;
               op_b   <= op_b >> 1;
               sum_sh <= sum_next[WIDTH-1:1];
               carry  <= cell_co;
               cnt    <= cnt + 6'd1;
               if (last_bit) begin
                  sum_q <= sum_next;
                  co_q  <= cell_co;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = (state == DONE);
   assign bus.Sum       = sum_q;
   assign bus.CO        = co_q;
   assign bus.state_dbg = state;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl. An 8-bit instance is driven with directed
// and random operations. A 2-bit instance is swept exhaustively.
// Expected results come from plain integer addition.
module tb_serial_add_ctrl;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   logic [7:0] prev_sum;
   logic       prev_co;

   serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
   serial_add_ctrl_if #(.WIDTH(2)) bus2 ();

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
   serial_add_ctrl #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One 8-bit operation. Outputs are sampled 1 time unit after each edge.
   // poke[k] asserts a stray start with A=FF right after edge k, and that
   // request must be ignored.
   task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [15:0] poke, input string tag);
      logic [8:0] exp_res;
      int busy_cnt;
      int done_cnt;
      int done_k;
      exp_res = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      bus8.start = 1'b1;
      bus8.A = a;
      bus8.B = b;
      bus8.CI = ci;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      bus8.A = 8'($urandom);
      bus8.B = 8'($urandom);
      bus8.CI = 1'($urandom);
      busy_cnt = bus8.busy ? 1 : 0;
      done_cnt = 0;
      done_k = -1;
      for (int k = 1; k <= 11; k++) begin
         @(posedge clk); #1;
         bus8.start = 1'b0;
         if (k == 1) check({tag, "_hold"}, {23'd0, bus8.CO, bus8.Sum}, {23'd0, prev_co, prev_sum});
         if (bus8.busy) busy_cnt++;
         if (bus8.done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
            check({tag, "_sum"}, {23'd0, bus8.CO, bus8.Sum}, {23'd0, exp_res});
         end
         if (poke[k]) begin
            bus8.start = 1'b1;
            bus8.A = 8'hFF;
            bus8.B = 8'($urandom);
         end
      end
      check({tag, "_done_at"}, done_k, 8);
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_busy_cycles"}, busy_cnt, 9);
      check({tag, "_held"}, {23'd0, bus8.CO, bus8.Sum}, {23'd0, exp_res});
      prev_sum = exp_res[7:0];
      prev_co  = exp_res[8];
   endtask

   // One 2-bit operation on the small instance, checked against integer addition.
   task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input logic ci);
      int exp_res;
      int done_k;
      exp_res = int'(a) + int'(b) + int'(ci);
      bus2.start = 1'b1;
      bus2.A = a;
      bus2.B = b;
      bus2.CI = ci;
      @(posedge clk); #1;
      bus2.start = 1'b0;
      done_k = -1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         if (bus2.done && done_k < 0) begin
            done_k = k;
            check($sformatf("w2_%0d_%0d_%0d", a, b, ci), {29'd0, bus2.CO, bus2.Sum}, 32'(exp_res));
         end
      end
      check($sformatf("w2_done_at_%0d_%0d_%0d", a, b, ci), done_k, 2);
   endtask

   // Directed and random stimulus.
   initial begin
      int done_seen;
      logic [7:0] ra, rb;
      logic rc;
      total = 0;
      bad = 0;
      prev_sum = 8'h00;
      prev_co = 1'b0;
      rst_n = 1'b0;
      bus8.start = 1'b0; bus8.A = '0; bus8.B = '0; bus8.CI = 1'b0;
      bus2.start = 1'b0; bus2.A = '0; bus2.B = '0; bus2.CI = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", bus8.busy, 0);
      check("rst_done", bus8.done, 0);
      check("rst_result", {23'd0, bus8.CO, bus8.Sum}, 0);
      check("rst_w2", {28'd0, bus2.busy, bus2.done, bus2.CO, bus2.Sum}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op8(8'h00, 8'h00, 1'b0, 16'h0, "zero");
      run_op8(8'hFF, 8'h01, 1'b0, 16'h0, "wrap");
      run_op8(8'hA5, 8'h5A, 1'b1, 16'h0, "ripple");
      run_op8(8'h3C, 8'h0F, 1'b0, 16'h0, "mix");
      run_op8(8'h10, 8'h01, 1'b0, 16'h0108, "ignore_start");
      run_op8(8'hFF, 8'hFF, 1'b1, 16'h0, "max");

      // Reset in the middle of an addition.
      bus8.start = 1'b1; bus8.A = 8'h77; bus8.B = 8'h66; bus8.CI = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", bus8.busy, 0);
      check("midrst_done", bus8.done, 0);
      check("midrst_result", {23'd0, bus8.CO, bus8.Sum}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      done_seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (bus8.done) done_seen++;
      end
      check("midrst_no_done", done_seen, 0);
      prev_sum = 8'h00;
      prev_co = 1'b0;
      run_op8(8'h02, 8'h03, 1'b0, 16'h0, "after_rst");

      // Random operations.
      for (int n = 0; n < 20; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom_range(1, 0));
         run_op8(ra, rb, rc, 16'($urandom_range(1, 0)) << 4, $sformatf("rand%0d", n));
      end

      // Exhaustive sweep of the 2-bit instance.
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < 2; c++)
               run_op2(2'(a), 2'(b), 1'(c));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
